timer_apb_ctrl: RTL and testbench

//  APB3 slave front-end for the 64-bit timer register file. Sequences every
//  APB transfer through IDLE/WAIT/ACCESS with programmable wait states.

---
 rtl/timer_apb_ctrl.sv | 107 ++++++++++
 tb/tb_timer_apb_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_ctrl.sv
// APB3 slave front-end for the 64-bit timer register file.
// Every transfer is sequenced IDLE -> (WAIT x WAIT_STATES) -> ACCESS. The
// setup-phase address, data, strobes and direction are captured once and
// held, so later bus changes within a transfer have no effect. Strobes and
// bus responses decode from the registered state, qualified by psel/penable
// so that a master that abandons the access phase never sees pready.
module timer_apb_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic              wr_en,
  output logic              rd_en,
  output logic              tim_pready,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic [3:0]        strb,
  input  logic [31:0]       rdata_in,
  input  logic              error_in
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Counter preload; with zero wait states the WAIT state is never entered.
  localparam logic [3:0] WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t            state_q;
  logic [3:0]        wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic              write_q;

  logic access_ok;
  logic misaligned;

  // Transfer sequencer: captures the setup phase and counts wait states.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (psel && !penable) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            // Reads carry no byte lanes to the register block.
            strb_q  <= pwrite ? pstrb : 4'd0;
            write_q <= pwrite;
            wcnt_q  <= WCNT_INIT;
            state_q <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state_q <= ST_IDLE;
          end else if (wcnt_q == 4'd0) begin
            state_q <= ST_ACCESS;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The access cycle only completes if the master is still in its access phase.
  assign access_ok  = (state_q == ST_ACCESS) && psel && penable;
  assign misaligned = (addr_q[1:0] != 2'b00);

  assign pready     = access_ok;
  assign tim_pready = access_ok;
  assign wr_en      = access_ok && write_q && !misaligned;
  assign rd_en      = access_ok && !write_q && !misaligned;
  assign prdata     = rd_en ? rdata_in : 32'd0;
  assign pslverr    = access_ok && (error_in || misaligned);

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign strb  = strb_q;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Directed bench for timer_apb_ctrl: a per-cycle vector table on a
// one-wait-state instance, plus hand sequences for abort, reset and
// zero-wait back-to-back transfers on three-wait and zero-wait instances.
module tb_timer_apb_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] rdata_in;
  logic        error_in;

  logic        pready_a     [3];
  logic [31:0] prdata_a     [3];
  logic        pslverr_a    [3];
  logic        wr_en_a      [3];
  logic        rd_en_a      [3];
  logic        tim_pready_a [3];
  logic [11:0] addr_a       [3];
  logic [31:0] wdata_a      [3];
  logic [3:0]  strb_a       [3];

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  timer_apb_ctrl #(.WAIT_STATES(1), .ADDR_W(12)) dut_ws1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_a[0]), .prdata(prdata_a[0]), .pslverr(pslverr_a[0]),
    .wr_en(wr_en_a[0]), .rd_en(rd_en_a[0]), .tim_pready(tim_pready_a[0]),
    .addr(addr_a[0]), .wdata(wdata_a[0]), .strb(strb_a[0]),
    .rdata_in(rdata_in), .error_in(error_in));

  timer_apb_ctrl #(.WAIT_STATES(3), .ADDR_W(12)) dut_ws3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_a[1]), .prdata(prdata_a[1]), .pslverr(pslverr_a[1]),
    .wr_en(wr_en_a[1]), .rd_en(rd_en_a[1]), .tim_pready(tim_pready_a[1]),
    .addr(addr_a[1]), .wdata(wdata_a[1]), .strb(strb_a[1]),
    .rdata_in(rdata_in), .error_in(error_in));

  timer_apb_ctrl #(.WAIT_STATES(0), .ADDR_W(12)) dut_ws0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_a[2]), .prdata(prdata_a[2]), .pslverr(pslverr_a[2]),
    .wr_en(wr_en_a[2]), .rd_en(rd_en_a[2]), .tim_pready(tim_pready_a[2]),
    .addr(addr_a[2]), .wdata(wdata_a[2]), .strb(strb_a[2]),
    .rdata_in(rdata_in), .error_in(error_in));

  typedef struct {
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] rdata_in;
    logic        error_in;
    logic        e_pready;
    logic [31:0] e_prdata;
    logic        e_pslverr, e_wr, e_rd;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic ps, input logic pe, input logic pw, input logic [11:0] pa,
    input logic [31:0] pd, input logic [3:0] pst, input logic [31:0] rd,
    input logic er, input logic e_rdy, input logic [31:0] e_prd,
    input logic e_err, input logic e_w, input logic e_r,
    input logic [11:0] e_a, input logic [31:0] e_wd, input logic [3:0] e_s);
    vec_t v;
    v.psel = ps; v.penable = pe; v.pwrite = pw; v.paddr = pa; v.pwdata = pd;
    v.pstrb = pst; v.rdata_in = rd; v.error_in = er;
    v.e_pready = e_rdy; v.e_prdata = e_prd; v.e_pslverr = e_err;
    v.e_wr = e_w; v.e_rd = e_r; v.e_addr = e_a; v.e_wdata = e_wd; v.e_strb = e_s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait for the sampling point, then for the next cycle's drive point.
  task automatic to_sample();
    @(negedge sys_clk);
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic ps, input logic pe, input logic pw,
                       input logic [11:0] pa, input logic [31:0] pd,
                       input logic [3:0] pst, input logic [31:0] rd, input logic er);
    psel = ps; penable = pe; pwrite = pw; paddr = pa; pwdata = pd;
    pstrb = pst; rdata_in = rd; error_in = er;
  endtask

  task automatic chk_quiet(input int k, input string tag);
    chk($sformatf("%s pready", tag), 32'(pready_a[k]), 32'd0);
    chk($sformatf("%s wr_en", tag), 32'(wr_en_a[k]), 32'd0);
    chk($sformatf("%s rd_en", tag), 32'(rd_en_a[k]), 32'd0);
    chk($sformatf("%s pslverr", tag), 32'(pslverr_a[k]), 32'd0);
    chk($sformatf("%s prdata", tag), prdata_a[k], 32'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    drive(0, 0, 0, 12'h000, 32'd0, 4'd0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    sys_rst = 1'b0;
  endtask

  // One full transfer on instance k: setup, ws wait cycles, one access cycle.
  task automatic do_xfer(input int k, input int ws, input logic wr, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input logic [31:0] rd,
                         input logic err, input logic exp_err, input logic exp_wr,
                         input logic exp_rd, input logic [31:0] exp_prd, input string tag);
    drive(1, 0, wr, a, wd, st, rd, 1'b0);
    to_sample();
    chk_quiet(k, $sformatf("%s setup", tag));
    next_cycle();
    for (int i = 0; i < ws; i++) begin
      drive(1, 1, wr, a, wd, st, rd, 1'b0);
      to_sample();
      chk_quiet(k, $sformatf("%s wait%0d", tag, i));
      next_cycle();
    end
    drive(1, 1, wr, a, wd, st, rd, err);
    to_sample();
    chk($sformatf("%s acc pready", tag), 32'(pready_a[k]), 32'd1);
    chk($sformatf("%s acc tim_pready", tag), 32'(tim_pready_a[k]), 32'd1);
    chk($sformatf("%s acc pslverr", tag), 32'(pslverr_a[k]), 32'(exp_err));
    chk($sformatf("%s acc wr_en", tag), 32'(wr_en_a[k]), 32'(exp_wr));
    chk($sformatf("%s acc rd_en", tag), 32'(rd_en_a[k]), 32'(exp_rd));
    chk($sformatf("%s acc prdata", tag), prdata_a[k], exp_prd);
    chk($sformatf("%s acc addr", tag), 32'(addr_a[k]), 32'(a));
    chk($sformatf("%s acc wdata", tag), wdata_a[k], wd);
    chk($sformatf("%s acc strb", tag), 32'(strb_a[k]), wr ? 32'(st) : 32'd0);
    $display("xfer %s: k=%0d wr=%0d addr=0x%03h pready=%0d pslverr=%0d prdata=0x%08h",
             tag, k, wr, a, pready_a[k], pslverr_a[k], prdata_a[k]);
    next_cycle();
  endtask

  initial begin
    // Table for the one-wait-state instance, one row per clock cycle.
    //            psel pen wr paddr   pwdata        pstrb rdata_in      err | rdy prdata        err wr rd addr    wdata         strb
    tbl[0]  = mk(0, 0, 0, 12'h000, 32'h0,         4'h0, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h000, 32'h0,         4'h0);
    tbl[1]  = mk(1, 0, 1, 12'h000, 32'h0000_0103, 4'hF, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h000, 32'h0,         4'h0);
    tbl[2]  = mk(1, 1, 1, 12'h000, 32'h0000_0103, 4'hF, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h000, 32'h0000_0103, 4'hF);
    tbl[3]  = mk(1, 1, 1, 12'h000, 32'h0000_0103, 4'hF, 32'h0,         0,  1, 32'h0,         0, 1, 0, 12'h000, 32'h0000_0103, 4'hF);
    tbl[4]  = mk(0, 0, 0, 12'h000, 32'h0,         4'h0, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h000, 32'h0000_0103, 4'hF);
    tbl[5]  = mk(1, 0, 0, 12'h004, 32'h0,         4'hF, 32'hDEAD_BEEF, 0,  0, 32'h0,         0, 0, 0, 12'h000, 32'h0000_0103, 4'hF);
    tbl[6]  = mk(1, 1, 0, 12'h004, 32'h0,         4'hF, 32'hDEAD_BEEF, 0,  0, 32'h0,         0, 0, 0, 12'h004, 32'h0,         4'h0);
    tbl[7]  = mk(1, 1, 0, 12'h004, 32'h0,         4'hF, 32'hDEAD_BEEF, 0,  1, 32'hDEAD_BEEF, 0, 0, 1, 12'h004, 32'h0,         4'h0);
    tbl[8]  = mk(0, 0, 0, 12'h000, 32'h0,         4'h0, 32'hDEAD_BEEF, 0,  0, 32'h0,         0, 0, 0, 12'h004, 32'h0,         4'h0);
    tbl[9]  = mk(1, 0, 1, 12'h006, 32'h0000_0055, 4'h3, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h004, 32'h0,         4'h0);
    tbl[10] = mk(1, 1, 1, 12'h100, 32'h0000_0099, 4'hF, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h006, 32'h0000_0055, 4'h3);
    tbl[11] = mk(1, 1, 1, 12'h100, 32'h0000_0099, 4'hF, 32'h0,         0,  1, 32'h0,         1, 0, 0, 12'h006, 32'h0000_0055, 4'h3);
    tbl[12] = mk(0, 0, 0, 12'h000, 32'h0,         4'h0, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h006, 32'h0000_0055, 4'h3);
    tbl[13] = mk(1, 0, 0, 12'h009, 32'h0,         4'h0, 32'h1234_5678, 0,  0, 32'h0,         0, 0, 0, 12'h006, 32'h0000_0055, 4'h3);
    tbl[14] = mk(1, 1, 0, 12'h009, 32'h0,         4'h0, 32'h1234_5678, 1,  0, 32'h0,         0, 0, 0, 12'h009, 32'h0,         4'h0);
    tbl[15] = mk(1, 1, 0, 12'h009, 32'h0,         4'h0, 32'h1234_5678, 0,  1, 32'h0,         1, 0, 0, 12'h009, 32'h0,         4'h0);
    tbl[16] = mk(1, 0, 0, 12'h008, 32'h0,         4'h0, 32'hCAFE_F00D, 0,  0, 32'h0,         0, 0, 0, 12'h009, 32'h0,         4'h0);
    tbl[17] = mk(1, 1, 0, 12'h008, 32'h0,         4'h0, 32'hCAFE_F00D, 1,  0, 32'h0,         0, 0, 0, 12'h008, 32'h0,         4'h0);
    tbl[18] = mk(1, 1, 0, 12'h008, 32'h0,         4'h0, 32'hCAFE_F00D, 1,  1, 32'hCAFE_F00D, 1, 0, 1, 12'h008, 32'h0,         4'h0);
    tbl[19] = mk(0, 0, 0, 12'h000, 32'h0,         4'h0, 32'h0,         0,  0, 32'h0,         0, 0, 0, 12'h008, 32'h0,         4'h0);

    // Reset state of every instance, with the bus held idle.
    sys_rst = 1'b1;
    drive(0, 0, 0, 12'h000, 32'd0, 4'd0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    to_sample();
    for (int k = 0; k < 3; k++) begin
      chk_quiet(k, $sformatf("reset k%0d", k));
      chk($sformatf("reset k%0d addr", k), 32'(addr_a[k]), 32'd0);
      chk($sformatf("reset k%0d wdata", k), wdata_a[k], 32'd0);
      chk($sformatf("reset k%0d strb", k), 32'(strb_a[k]), 32'd0);
    end
    $display("reset: outputs sampled with sys_rst high");
    next_cycle();
    sys_rst = 1'b0;

    // Vector table on the one-wait-state instance.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].psel, tbl[i].penable, tbl[i].pwrite, tbl[i].paddr,
            tbl[i].pwdata, tbl[i].pstrb, tbl[i].rdata_in, tbl[i].error_in);
      to_sample();
      chk($sformatf("row%0d pready", i), 32'(pready_a[0]), 32'(tbl[i].e_pready));
      chk($sformatf("row%0d tim_pready", i), 32'(tim_pready_a[0]), 32'(tbl[i].e_pready));
      chk($sformatf("row%0d prdata", i), prdata_a[0], tbl[i].e_prdata);
      chk($sformatf("row%0d pslverr", i), 32'(pslverr_a[0]), 32'(tbl[i].e_pslverr));
      chk($sformatf("row%0d wr_en", i), 32'(wr_en_a[0]), 32'(tbl[i].e_wr));
      chk($sformatf("row%0d rd_en", i), 32'(rd_en_a[0]), 32'(tbl[i].e_rd));
      chk($sformatf("row%0d addr", i), 32'(addr_a[0]), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d wdata", i), wdata_a[0], tbl[i].e_wdata);
      chk($sformatf("row%0d strb", i), 32'(strb_a[0]), 32'(tbl[i].e_strb));
      $display("row %0d: psel=%0d pen=%0d wr=%0d paddr=0x%03h pready=%0d wr_en=%0d rd_en=%0d pslverr=%0d prdata=0x%08h",
               i, psel, penable, pwrite, paddr, pready_a[0], wr_en_a[0], rd_en_a[0],
               pslverr_a[0], prdata_a[0]);
      next_cycle();
    end

    // Three wait states, psel dropped in the second wait cycle.
    do_reset();
    drive(1, 0, 1, 12'h020, 32'h0000_00AA, 4'hF, 32'd0, 1'b0);
    to_sample();
    chk_quiet(1, "abort setup");
    next_cycle();
    drive(1, 1, 1, 12'h020, 32'h0000_00AA, 4'hF, 32'd0, 1'b0);
    to_sample();
    chk_quiet(1, "abort wait0");
    next_cycle();
    drive(0, 0, 1, 12'h020, 32'h0000_00AA, 4'hF, 32'd0, 1'b0);
    to_sample();
    chk_quiet(1, "abort wait1");
    next_cycle();
    $display("abort: psel dropped in second wait cycle");
    // The instance must be idle now, so a new setup here is accepted at once.
    do_xfer(1, 3, 1'b1, 12'h024, 32'h0000_00BB, 4'h5, 32'd0, 1'b0,
            1'b0, 1'b1, 1'b0, 32'd0, "after_abort");

    // Reset asserted during a wait cycle, with the master still in access phase.
    do_reset();
    drive(1, 0, 1, 12'h030, 32'h0000_0077, 4'hF, 32'd0, 1'b0);
    next_cycle();
    drive(1, 1, 1, 12'h030, 32'h0000_0077, 4'hF, 32'd0, 1'b0);
    next_cycle();
    sys_rst = 1'b1;
    next_cycle();
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      to_sample();
      chk_quiet(1, $sformatf("rst_mid c%0d", i));
      chk($sformatf("rst_mid c%0d addr", i), 32'(addr_a[1]), 32'd0);
      chk($sformatf("rst_mid c%0d wdata", i), wdata_a[1], 32'd0);
      chk($sformatf("rst_mid c%0d strb", i), 32'(strb_a[1]), 32'd0);
      next_cycle();
    end
    $display("rst_mid: reset during wait dropped the transfer");
    drive(0, 0, 0, 12'h000, 32'd0, 4'd0, 32'd0, 1'b0);
    next_cycle();
    do_xfer(1, 3, 1'b0, 12'h040, 32'd0, 4'hF, 32'h0BAD_F00D, 1'b0,
            1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, "after_rst");

    // Zero wait states, two back-to-back writes, error on the second.
    do_reset();
    do_xfer(2, 0, 1'b1, 12'h010, 32'h1111_1111, 4'hF, 32'd0, 1'b0,
            1'b0, 1'b1, 1'b0, 32'd0, "b2b_1");
    do_xfer(2, 0, 1'b1, 12'h014, 32'h2222_2222, 4'hC, 32'd0, 1'b1,
            1'b1, 1'b1, 1'b0, 32'd0, "b2b_2");
    drive(0, 0, 0, 12'h000, 32'd0, 4'd0, 32'd0, 1'b1);
    to_sample();
    chk_quiet(2, "b2b idle");
    chk("b2b idle addr hold", 32'(addr_a[2]), 32'h014);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
